// File: rtl/fu_mul_seq.sv
// Iterative shift-and-add multiplier that drives an external FU for every add and
// multiplicand shift, returning the low 32 bits of A*B plus an overflow flag.
module fu_mul_seq #(
    parameter logic [5:0] CTRL_ADD = 6'b000000,
    parameter logic [5:0] CTRL_SHL = 6'b100000,
    parameter logic [5:0] CTRL_NOP = 6'b000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_product,
    output logic        out_ovf,
    output logic [31:0] fu_a,
    output logic [31:0] fu_b,
    output logic [5:0]  fu_ctrl,
    input  logic [31:0] fu_f,
    input  logic [5:0]  fu_status
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_SHL,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic        ovf_q, ovf_d;

    // Only the carry flag of the FU status is meaningful to this sequencer.
    logic unused_status;
    assign unused_status = ^{fu_status[5:4], fu_status[2:0]};

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: every output of this block is defaulted first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        ovf_d    = ovf_q;
        fu_a     = '0;
        fu_b     = '0;
        fu_ctrl  = CTRL_NOP;
        in_ready = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d    = '0;
                    mcand_d  = in_a;
                    mplier_d = in_b;
                    ovf_d    = 1'b0;
                    state_d  = S_ADD;
                end
            end
            S_ADD: begin
                fu_a = acc_q;
                fu_b = mcand_q;
                if (mplier_q[0]) begin
                    fu_ctrl = CTRL_ADD;
                    acc_d   = fu_f;
                    ovf_d   = ovf_q | fu_status[3];
                end
                state_d = S_SHL;
            end
            S_SHL: begin
                fu_a     = mcand_q;
                fu_b     = 32'd1;
                fu_ctrl  = CTRL_SHL;
                mcand_d  = fu_f;
                mplier_d = mplier_q >> 1;
                // A multiplicand bit shifted out still has multiplier bits left to meet.
                if ((mplier_d != '0) && mcand_q[31]) begin
                    ovf_d = 1'b1;
                end
                state_d = (mplier_d == '0) ? S_DONE : S_ADD;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign out_valid   = (state_q == S_DONE);
    assign out_product = acc_q;
    assign out_ovf     = ovf_q;

endmodule

// File: tb/tb_fu_mul_seq.sv
// Directed bench for fu_mul_seq: a behavioural FU model answers the sequencer, a
// driver queues expected results and a monitor compares them at each output transfer.
module tb_fu_mul_seq;

    localparam logic [5:0] CTRL_NOP = 6'b000000;
    localparam logic [5:0] CTRL_SHL = 6'b100000;

    typedef struct {
        logic [31:0] product;
        logic        ovf;
    } result_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_product;
    logic        out_ovf;
    logic [31:0] fu_a;
    logic [31:0] fu_b;
    logic [5:0]  fu_ctrl;
    logic [31:0] fu_f;
    logic [5:0]  fu_status;
    logic [32:0] fu_sum;

    int n_checks = 0;
    int n_fail   = 0;
    result_t exp_q[$];

    fu_mul_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_product(out_product),
        .out_ovf    (out_ovf),
        .fu_a       (fu_a),
        .fu_b       (fu_b),
        .fu_ctrl    (fu_ctrl),
        .fu_f       (fu_f),
        .fu_status  (fu_status)
    );

    always #5 clk = ~clk;

    // Behavioural FU: bit5 selects the shifter, otherwise a 32-bit add with carry.
    assign fu_sum = {1'b0, fu_a} + {1'b0, fu_b};
    always_comb begin
        fu_f      = '0;
        fu_status = '0;
        if (fu_ctrl[5]) begin
            fu_f      = fu_a << fu_b[4:0];
            fu_status = {fu_f[31], 1'b0, 1'b0, (fu_f == '0), 2'b00};
        end else begin
            fu_f      = fu_sum[31:0];
            fu_status = {fu_sum[31], (fu_a[31] == fu_b[31]) && (fu_sum[31] != fu_a[31]),
                         fu_sum[32], (fu_sum[31:0] == '0), 2'b00};
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every output transfer must match the oldest queued expectation.
    initial begin
        result_t r;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'(out_product), 64'hDEAD);
                end else begin
                    r = exp_q.pop_front();
                    check("product", 64'(out_product), 64'(r.product));
                    check("ovf", 64'(out_ovf), 64'(r.ovf));
                end
            end
        end
    end

    // Called at posedge+1: presents a command and returns just after the accepting edge.
    task automatic accept(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] p, input logic o, input bit push);
        result_t r;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        check("accept_ready", 64'(in_ready), 64'd1);
        if (push) begin
            r.product = p;
            r.ovf     = o;
            exp_q.push_back(r);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Latency counts edges from the accepting edge (inclusive) until out_valid is seen.
    task automatic wait_valid(input int start, input int exp_lat);
        int lat = start;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] p, input logic o, input int exp_lat);
        accept(a, b, p, o, 1'b1);
        wait_valid(1, exp_lat);
        @(posedge clk);
        #1;
        check("valid_drop", 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [31:0] held_p;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_product", 64'(out_product), 64'd0);
        check("rst_ovf", 64'(out_ovf), 64'd0);
        check("rst_fu_a", 64'(fu_a), 64'd0);
        check("rst_fu_b", 64'(fu_b), 64'd0);
        check("rst_fu_ctrl", 64'(fu_ctrl), 64'(CTRL_NOP));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset asserted during SHL abandons the operation immediately.
        accept(32'd5, 32'd3, 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("midop_in_shl", 64'(fu_ctrl), 64'(CTRL_SHL));
        rst_n = 1'b0;
        #1;
        check("midop_out_valid", 64'(out_valid), 64'd0);
        check("midop_in_ready", 64'(in_ready), 64'd1);
        check("midop_fu_ctrl", 64'(fu_ctrl), 64'(CTRL_NOP));
        check("midop_fu_a", 64'(fu_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(32'd7, 32'd6, 32'd42, 1'b0, 7);

        // Basic with FU operand probes in the first ADD and SHL.
        accept(32'd7, 32'd6, 32'd42, 1'b0, 1'b1);
        check("add0_fu_ctrl", 64'(fu_ctrl), 64'(CTRL_NOP));
        check("add0_fu_a", 64'(fu_a), 64'd0);
        check("add0_fu_b", 64'(fu_b), 64'd7);
        @(posedge clk);
        #1;
        check("shl0_fu_ctrl", 64'(fu_ctrl), 64'(CTRL_SHL));
        check("shl0_fu_a", 64'(fu_a), 64'd7);
        check("shl0_fu_b", 64'(fu_b), 64'd1);
        wait_valid(2, 7);
        @(posedge clk);
        #1;

        run_op(32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 3);
        run_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 3);
        run_op(32'h8000_0000, 32'd2, 32'd0, 1'b1, 5);
        run_op(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 35);
        run_op(32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 1'b0, 33);
        run_op(32'd3, 32'h8000_0000, 32'h8000_0000, 1'b1, 65);

        // Backpressure: result held for 10 cycles while a new command waits.
        out_ready = 1'b0;
        accept(32'd9, 32'd9, 32'd81, 1'b0, 1'b1);
        wait_valid(1, 9);
        held_p   = out_product;
        in_a     = 32'd2;
        in_b     = 32'd3;
        in_valid = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_product", 64'(out_product), 64'(held_p));
            check("bp_ovf", 64'(out_ovf), 64'd0);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_after_hs_valid", 64'(out_valid), 64'd0);
        check("bp_after_hs_ready", 64'(in_ready), 64'd1);
        accept(32'd2, 32'd3, 32'd6, 1'b0, 1'b1);
        wait_valid(1, 5);
        @(posedge clk);
        #1;

        repeat (3) @(posedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fu_mul_seq.md
Name: fu_mul_seq

Overview:
- Iterative unsigned multiplier sequencer. It drives the FU (ALU + shifter + output mux) as an initiator: it issues one FU operation per cycle and consumes the FU's F and status outputs.
- Computes the low 32 bits of A*B by shift-and-add, using the FU for all adds and multiplicand shifts.
- Sits beside the FU in the datapath, with a valid/ready command port and a valid/ready result port.

Parameters:
- CTRL_ADD, 6'b000000, FU control_signals for a 32-bit add A+B (bit5=0 selects ALU; carry appears on status[3]).
- CTRL_SHL, 6'b100000, FU control_signals for a logical left shift of A by B[4:0] (bit5=1 selects shifter; [3:2]=00).
- CTRL_NOP, 6'b000000, FU control_signals driven whenever no FU result is consumed.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  command valid.
- in_ready  out  1  sequencer can accept a command.
- in_a  in  32  multiplicand.
- in_b  in  32  multiplier.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_product  out  32  low 32 bits of in_a*in_b.
- out_ovf  out  1  true product exceeds 32 bits.
- fu_a  out  32  FU operand A.
- fu_b  out  32  FU operand B.
- fu_ctrl  out  6  FU control_signals.
- fu_f  in  32  FU result F.
- fu_status  in  6  FU status {N,V,C,Z,LT,ULT}; only [3]=C is used.

Behaviour:
- Internal registers: acc[31:0], mcand[31:0], mplier[31:0], ovf, state ∈ {IDLE, ADD, SHL, DONE}.
- Reset (async, rst_n=0):
  - state=IDLE; acc, mcand, mplier = 0; ovf=0.
  - out_valid=0, out_product=0, out_ovf=0, in_ready=1.
  - fu_a=0, fu_b=0, fu_ctrl=CTRL_NOP.
  - Reset asserted mid-operation discards the operation; no result is produced.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: acc<=0, mcand<=in_a, mplier<=in_b, ovf<=0, go to ADD.
  - Otherwise stay.
- ADD:
  - fu_a=acc, fu_b=mcand.
  - If mplier[0]=1: fu_ctrl=CTRL_ADD, acc<=fu_f, ovf<=ovf|fu_status[3].
  - If mplier[0]=0: fu_ctrl=CTRL_NOP, acc unchanged.
  - Always go to SHL.
- SHL:
  - fu_a=mcand, fu_b=32'd1, fu_ctrl=CTRL_SHL; mcand<=fu_f; mplier<=mplier>>1 (internal shift, not via FU).
  - If (mplier>>1)!=0 and mcand[31]=1: ovf<=1 (a bit lost that would still be added).
  - If (mplier>>1)==0: go to DONE; else go to ADD.
- DONE:
  - out_valid=1; out_product=acc; out_ovf=ovf (both registered and stable while out_valid).
  - On out_ready: go to IDLE; out_valid drops next cycle.
- In states other than IDLE and ADD/SHL: fu_a=0, fu_b=0, fu_ctrl=CTRL_NOP.
- in_ready=0 in ADD, SHL, DONE; commands there are not accepted and must be held by the source.
- Latency:
  - k = max(1, index of MSB of in_b + 1).
  - out_valid rises 2k+1 cycles after the accepting edge; maximum 65 cycles (in_b[31]=1).
  - in_b=0 follows ADD(no-op) → SHL → DONE: product 0, ovf 0, latency 3.
- out_ready=1 already when DONE is entered: result transfers on that edge; IDLE is next cycle (no same-cycle re-accept).
- Arithmetic: unsigned, modulo 2^32 for out_product. out_ovf=1 iff the exact 64-bit product ≥ 2^32.

Test Plan:
- Reset mid-op: in_a=5, in_b=3 accepted, rst_n low during SHL → out_valid=0, in_ready=1, fu_ctrl=CTRL_NOP immediately; a following 7*6 → out_product=42.
- Basic: in_a=7, in_b=6 → out_product=42, out_ovf=0, out_valid 7 cycles after accept; fu_ctrl=CTRL_NOP in first ADD (bit0=0).
- Zero/one: in_a=0xFFFFFFFF, in_b=0 → product 0, ovf 0, latency 3; in_a=0xFFFFFFFF, in_b=1 → product 0xFFFFFFFF, ovf 0, latency 3.
- Overflow: in_a=0x80000000, in_b=2 → product 0, ovf 1; in_a=0x10000, in_b=0x10000 → product 0, ovf 1; in_a=0xFFFF, in_b=0xFFFF → 0xFFFE0001, ovf 0.
- Backpressure: out_ready=0 for 10 cycles in DONE → out_valid, out_product, out_ovf stable; in_valid held high is not accepted until the cycle after the out handshake.
- Max latency: in_a=3, in_b=0x80000000 → product 0x80000000, ovf 1, out_valid 65 cycles after accept.
